config_sequencer: RTL and testbench
===================================

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the configuration address bus.
REQ-002 Parameter DATA_WIDTH, default 32, width of the configuration data, read-back and response buses.
REQ-003 Parameter READ_LATENCY, default 1, range 1..15: cycles from config_addr stable to read_data valid.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready are both high at a rising edge.
REQ-008 cmd_op  input  2  00 WRITE, 01 READ, 10 VERIFY, 11 reserved (treated as READ).
REQ-009 cmd_addr  input  ADDR_WIDTH  target register address.
REQ-010 cmd_data  input  DATA_WIDTH  write data for WRITE; expected value for VERIFY.
REQ-011 config_addr  output  ADDR_WIDTH  address driven to tiles.
REQ-012 config_data  output  DATA_WIDTH  write data driven to tiles.
REQ-013 config_en  output  1  tile write strobe.
REQ-014 read_data  input  DATA_WIDTH  tile read-back of the register at config_addr.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  response consumed when rsp_valid & rsp_ready are both high at a rising edge.
REQ-017 rsp_data  output  DATA_WIDTH  captured read_data.
REQ-018 rsp_err  output  1  VERIFY mismatch flag; 0 for READ.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, READ_WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 All outputs SHALL be registered.
REQ-021 WRITE accepted at edge N: config_addr/config_data updated at N; config_en high for exactly cycle N..N+1; state returns to IDLE at N+1; no response issued.
REQ-022 READ/VERIFY accepted at edge N: config_addr updated at N, config_en held 0, state goes to READ_WAIT.
REQ-023 READ_WAIT SHALL count READ_LATENCY cycles, then capture read_data into rsp_data and enter RESP.
REQ-024 For VERIFY, rsp_err SHALL be set to (captured read_data != cmd_data) in the same capture cycle.
REQ-025 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready; on handshake, clear rsp_valid and return to IDLE.
REQ-026 config_addr and config_data SHALL retain their last values when idle.
REQ-027 Back-to-back WRITEs SHALL sustain one write per 2 cycles.
REQ-028 cmd_* SHALL be sampled only at acceptance; later changes are ignored.

Reset
REQ-029 Asserting reset_n low SHALL immediately clear config_en, rsp_valid and rsp_err, zero config_addr/config_data/rsp_data, and force state IDLE, aborting any command in flight.
REQ-030 cmd_ready SHALL be 1 from the first rising edge after reset_n deasserts.

Configuration
REQ-031 With macro CONFIG_SEQ_ERR_CNT_EN defined, an output err_count (16 bits) SHALL count VERIFY mismatches, saturate at 16'hFFFF, and reset to 0.
REQ-032 Without CONFIG_SEQ_ERR_CNT_EN, there SHALL be no err_count port and no counter logic.

Structure
REQ-033 Package config_seq_pkg SHALL hold the cmd_op encodings, the FSM state enum and the default width constants.
REQ-034 The READ_LATENCY wait counter SHALL be a sub-module named config_seq_delay (load, count down, done).

Verification
REQ-035 WRITE addr=0, data=32'h1 -> config_en high for exactly one cycle, with config_addr=0 and config_data=1.
REQ-036 WRITE addr=0, data=32'h70, then READ addr=0, tile echoing the register -> rsp_data=32'h70, rsp_err=0, READ_LATENCY cycles after acceptance.
REQ-037 VERIFY addr=0, expected 32'h6, tile returns 32'h1 -> rsp_err=1; err_count increments by 1 when CONFIG_SEQ_ERR_CNT_EN is defined.
REQ-038 rsp_ready held low for 5 cycles -> rsp_valid, rsp_data and rsp_err stable; cmd_ready=0 throughout.
REQ-039 reset_n pulsed low during READ_WAIT -> outputs zero asynchronously; cmd_ready=1 after release; no stale response.
REQ-040 Ten back-to-back WRITEs -> ten config_en pulses in 20 cycles with matching addr/data order.

Source files
------------

// File: rtl/config_seq_pkg.sv
// Shared encodings, FSM state type and default widths for the configuration sequencer.
`timescale 1ns/1ps
package config_seq_pkg;

    localparam int DEFAULT_ADDR_WIDTH   = 32;
    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_READ_LATENCY = 1;

    // Wide enough for the largest supported read latency (15).
    localparam int DELAY_W = 4;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_VERIFY = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } seq_state_t;

    function automatic logic is_write_op(input logic [1:0] op);
        return op == OP_WRITE;
    endfunction

endpackage

// File: rtl/config_seq_delay.sv
// Read-latency wait counter: loads LATENCY on i_load, counts down, and flags
// o_done during the final wait cycle so the caller can capture on that edge.
`timescale 1ns/1ps
module config_seq_delay
    import config_seq_pkg::*;
#(
    parameter int LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_done
);

    logic [DELAY_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= DELAY_W'(LATENCY);
        end else if (r_count != '0) begin
            r_count <= r_count - DELAY_W'(1);
        end
    end

    assign o_done = (r_count == DELAY_W'(1));

endmodule

// File: rtl/config_sequencer.sv
// Sequences WRITE/READ/VERIFY commands onto the tile configuration bus.
// Optional macro CONFIG_SEQ_ERR_CNT_EN adds a saturating 16-bit err_count output.
`timescale 1ns/1ps
module config_sequencer
    import config_seq_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [ADDR_WIDTH-1:0] config_addr,
    output logic [DATA_WIDTH-1:0] config_data,
    output logic                  config_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
`ifdef CONFIG_SEQ_ERR_CNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    seq_state_t            r_state;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_config_addr;
    logic [DATA_WIDTH-1:0] r_config_data;
    logic                  r_config_en;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_is_verify;
    logic [DATA_WIDTH-1:0] r_expected;

    logic w_accept;
    logic w_load;
    logic w_delay_done;

    // cmd_ready is only ever high in IDLE, so it doubles as the acceptance qualifier.
    assign w_accept = r_cmd_ready && cmd_valid;
    assign w_load   = w_accept && !is_write_op(cmd_op);

    config_seq_delay #(
        .LATENCY (READ_LATENCY)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .o_done  (w_delay_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_config_addr <= '0;
            r_config_data <= '0;
            r_config_en   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_is_verify   <= 1'b0;
            r_expected    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready   <= 1'b0;
                        r_config_addr <= cmd_addr;
                        if (is_write_op(cmd_op)) begin
                            r_config_data <= cmd_data;
                            r_config_en   <= 1'b1;
                            r_state       <= WRITE;
                        end else begin
                            r_is_verify <= (cmd_op == OP_VERIFY);
                            r_expected  <= cmd_data;
                            r_state     <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    r_config_en <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                READ_WAIT: begin
                    if (w_delay_done) begin
                        r_rsp_data  <= read_data;
                        r_rsp_err   <= r_is_verify && (read_data != r_expected);
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign config_addr = r_config_addr;
    assign config_data = r_config_data;
    assign config_en   = r_config_en;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

`ifdef CONFIG_SEQ_ERR_CNT_EN
    logic [15:0] r_err_count;
    logic        w_mismatch;

    assign w_mismatch = (r_state == READ_WAIT) && w_delay_done && r_is_verify
                        && (read_data != r_expected);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (w_mismatch && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: timeline model of the command/response rules plus
// directed scenarios with hand-computed expectations; honours CONFIG_SEQ_ERR_CNT_EN.
`timescale 1ns/1ps
module tb_config_sequencer;

    localparam int LAT = 3;
    localparam logic [1:0] WR = 2'b00;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] VF = 2'b10;
    localparam logic [1:0] RS = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic [31:0] read_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
`ifdef CONFIG_SEQ_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    config_sequencer #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .read_data   (read_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
`ifdef CONFIG_SEQ_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    // Tile: a small register file written by the strobe and read back combinationally.
    logic [31:0] tileMem [16];
    initial for (int i = 0; i < 16; i++) tileMem[i] = '0;
    always @(posedge clk) if (config_en) tileMem[config_addr[3:0]] <= config_data;
    assign read_data = tileMem[config_addr[3:0]];

    // Behavioural model: each accepted command schedules its effects in cycles.
    logic [31:0] modelMem [16];
    initial for (int i = 0; i < 16; i++) modelMem[i] = '0;
    bit          mReady = 1'b0;
    bit          mEn = 1'b0;
    int          mWaitLeft = 0;
    bit          mRspValid = 1'b0;
    logic [31:0] mAddr = '0;
    logic [31:0] mData = '0;
    logic [31:0] mRspData = '0;
    bit          mRspErr = 1'b0;
    bit          mIsVerify = 1'b0;
    logic [31:0] mExpect = '0;
    int          mErrCount = 0;
    bit          mReadyBefore;
    bit          mAccepted;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mReady = 1'b0; mEn = 1'b0; mWaitLeft = 0; mRspValid = 1'b0;
            mAddr = '0; mData = '0; mRspData = '0; mRspErr = 1'b0; mErrCount = 0;
        end else begin
            mReadyBefore = mReady;
            mAccepted = 1'b0;
            if (mRspValid && rsp_ready) begin
                mRspValid = 1'b0;
            end else if (mWaitLeft > 0) begin
                mWaitLeft = mWaitLeft - 1;
                if (mWaitLeft == 0) begin
                    mRspValid = 1'b1;
                    mRspData = modelMem[mAddr[3:0]];
                    mRspErr = mIsVerify && (mRspData != mExpect);
                    if (mRspErr && mErrCount < 65535) mErrCount = mErrCount + 1;
                end
            end
            if (mEn) begin
                mEn = 1'b0;
            end else if (mReadyBefore && cmd_valid) begin
                mAccepted = 1'b1;
                mAddr = cmd_addr;
                if (cmd_op == WR) begin
                    mData = cmd_data;
                    mEn = 1'b1;
                    modelMem[cmd_addr[3:0]] = cmd_data;
                end else begin
                    mWaitLeft = LAT;
                    mIsVerify = (cmd_op == VF);
                    mExpect = cmd_data;
                end
            end
            mReady = !mAccepted && !mEn && (mWaitLeft == 0) && !mRspValid;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && checkEn) begin
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(mReady));
            checkOutput("config_en", 32'(config_en), 32'(mEn));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(mRspValid));
            checkOutput("config_addr", config_addr, mAddr);
            checkOutput("config_data", config_data, mData);
            if (mRspValid) begin
                checkOutput("rsp_data", rsp_data, mRspData);
                checkOutput("rsp_err", 32'(rsp_err), 32'(mRspErr));
            end
`ifdef CONFIG_SEQ_ERR_CNT_EN
            checkOutput("err_count", 32'(err_count), 32'(mErrCount));
`endif
        end
    end

    // Config-strobe monitor used by the back-to-back write scenario.
    bit          monOn = 1'b0;
    logic [31:0] monAddr [$];
    logic [31:0] monData [$];
    longint      monTime [$];
    always @(negedge clk) begin
        if (monOn && reset_n && config_en) begin
            monAddr.push_back(config_addr);
            monData.push_back(config_data);
            monTime.push_back(longint'($time));
        end
    end

    // Offers one command, waits for acceptance, then withdraws it and scrambles the fields.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] data);
        bit ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_data = data;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'(($urandom_range(0, 3)));
        cmd_addr = $urandom;
        cmd_data = $urandom;
    endtask

    task automatic waitResponse(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                return;
            end
        end
        checkOutput("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;

        #1;
        checkOutput("reset_config_en", 32'(config_en), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_config_addr", config_addr, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
        checkEn = 1'b1;

        // Single write: one strobe cycle with the written address and data.
        applyStimulus(WR, 32'h0, 32'h1);
        checkOutput("w1_en_high", 32'(config_en), 32'd1);
        checkOutput("w1_addr", config_addr, 32'h0);
        checkOutput("w1_data", config_data, 32'h1);
        @(negedge clk);
        checkOutput("w1_en_low", 32'(config_en), 32'd0);

        // Write then read back through the tile.
        applyStimulus(WR, 32'h0, 32'h70);
        applyStimulus(RD, 32'h0, 32'h0);
        waitResponse(lat);
        checkOutput("rd_latency", 32'(lat), 32'(LAT));
        checkOutput("rd_data", rsp_data, 32'h70);
        checkOutput("rd_err", 32'(rsp_err), 32'd0);

        // Reserved opcode behaves as READ; matching VERIFY reports no error.
        applyStimulus(WR, 32'h5, 32'hCAFE_0005);
        applyStimulus(RS, 32'h5, 32'hFFFF_FFFF);
        waitResponse(lat);
        checkOutput("rsvd_data", rsp_data, 32'hCAFE_0005);
        checkOutput("rsvd_err", 32'(rsp_err), 32'd0);
        applyStimulus(VF, 32'h5, 32'hCAFE_0005);
        waitResponse(lat);
        checkOutput("vf_ok_err", 32'(rsp_err), 32'd0);

        // Mismatching VERIFY while the consumer stalls for five cycles.
        applyStimulus(WR, 32'h0, 32'h1);
        rsp_ready = 1'b0;
        applyStimulus(VF, 32'h0, 32'h6);
        waitResponse(lat);
        checkOutput("vf_latency", 32'(lat), 32'(LAT));
        checkOutput("vf_bad_err", 32'(rsp_err), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_data", rsp_data, 32'h1);
            checkOutput("hold_err", 32'(rsp_err), 32'd1);
            checkOutput("hold_ready", 32'(cmd_ready), 32'd0);
        end
`ifdef CONFIG_SEQ_ERR_CNT_EN
        checkOutput("err_count_one", 32'(err_count), 32'd1);
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hs_valid_clr", 32'(rsp_valid), 32'd0);
        checkOutput("hs_ready_set", 32'(cmd_ready), 32'd1);

        // Reset pulse in the middle of a read wait.
        applyStimulus(RD, 32'h5, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_config_en", 32'(config_en), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_config_addr", config_addr, 32'd0);
        checkOutput("rst_config_data", config_data, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
`ifdef CONFIG_SEQ_ERR_CNT_EN
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
`endif
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("rst_ready_after", 32'(cmd_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        // Ten back-to-back writes: one strobe every two cycles, in order.
        monOn = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(WR, 32'(i), 32'hA000_0000 + 32'(i));
        repeat (3) @(negedge clk);
        monOn = 1'b0;
        checkOutput("b2b_count", 32'(monAddr.size()), 32'd10);
        if (monTime.size() == 10) begin
            checkOutput("b2b_span", 32'(monTime[9] - monTime[0]), 32'd180);
            for (int i = 0; i < 10; i++) begin
                checkOutput("b2b_addr", monAddr[i], 32'(i));
                checkOutput("b2b_data", monData[i], 32'hA000_0000 + 32'(i));
            end
        end

        // Read one back-to-back value to confirm the tile saw it.
        applyStimulus(RD, 32'h7, 32'h0);
        waitResponse(lat);
        checkOutput("b2b_readback", rsp_data, 32'hA000_0007);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
